// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
// Tick-driven pattern sequencer. It walks a programmable pattern of up to
// STEPS slots, advancing one slot every ticks_per_step tempo ticks. Each
// active slot produces a note value, a one-cycle trigger and a gate that
// stays high for gate_ticks ticks. Rest slots move the step index only.
//
// Ports:
//   clock_in        system clock, rising edge
//   reset           asynchronous active-high reset
//   tick            one-cycle tempo subdivision pulse
//   start / stop    one-cycle control pulses (stop has priority)
//   last_step       index of the final step before wrapping to 0
//   ticks_per_step  ticks per step (0 behaves as 1)
//   gate_ticks      gate length in ticks (0 = trigger only)
//   wr_*            pattern slot write port
//   note, gate, trigger, step, running   registered outputs
// ---------------------------------------------------------------------------
module step_sequencer #(
    parameter  int STEPS      = 16,
    parameter  int NOTE_WIDTH = 8,
    localparam int SW         = $clog2(STEPS)
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic [SW-1:0]         last_step,
    input  logic [3:0]            ticks_per_step,
    input  logic [3:0]            gate_ticks,
    input  logic                  wr_en,
    input  logic [SW-1:0]         wr_addr,
    input  logic [NOTE_WIDTH-1:0] wr_note,
    input  logic                  wr_active,
    output logic [NOTE_WIDTH-1:0] note,
    output logic                  gate,
    output logic                  trigger,
    output logic [SW-1:0]         step,
    output logic                  running
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [NOTE_WIDTH-1:0]   note_q,     note_d;
    logic                    gate_q,     gate_d;
    logic                    trigger_q,  trigger_d;
    logic [SW-1:0]           step_q,     step_d;
    logic                    running_q,  running_d;
    logic [3:0]              sub_cnt_q,  sub_cnt_d;
    logic [3:0]              gate_cnt_q, gate_cnt_d;

    logic [NOTE_WIDTH-1:0]   slot_note_q [STEPS];
    logic [STEPS-1:0]        slot_act_q;

    logic                    play_s;
    logic [SW-1:0]           play_idx_s;
    logic [SW-1:0]           next_idx_s;
    logic [3:0]              tps_m1_s;

    // Step-advance helpers: effective ticks-per-step minus one, and the wrap target.
    always_comb begin
        if (ticks_per_step == 4'd0) begin
            tps_m1_s = 4'd0;
        end else begin
            tps_m1_s = ticks_per_step - 4'd1;
        end
        // ">=" so that lowering last_step below the current step wraps at once
        if (step_q >= last_step) begin
            next_idx_s = '0;
        end else begin
            next_idx_s = step_q + SW'(1);
        end
    end

    // Next-state and output computation; stop beats start, start beats tick.
    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        trigger_d  = 1'b0;
        step_d     = step_q;
        sub_cnt_d  = sub_cnt_q;
        gate_cnt_d = gate_cnt_q;
        play_s     = 1'b0;
        play_idx_s = '0;

        if (stop) begin
            state_d    = ST_IDLE;
            step_d     = '0;
            sub_cnt_d  = 4'd0;
            gate_cnt_d = 4'd0;
        end else if (start) begin
            // (Re)arm: the tick arriving with start is not consumed
            state_d    = ST_ARMED;
            step_d     = '0;
            sub_cnt_d  = 4'd0;
            gate_cnt_d = 4'd0;
        end else if (tick) begin
            case (state_q)
                ST_ARMED: begin
                    play_s     = 1'b1;
                    play_idx_s = '0;
                    sub_cnt_d  = 4'd0;
                    state_d    = ST_RUN;
                end
                ST_RUN: begin
                    if (sub_cnt_q >= tps_m1_s) begin
                        play_s     = 1'b1;
                        play_idx_s = next_idx_s;
                        sub_cnt_d  = 4'd0;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 4'd1;
                        // Gate only counts down on ticks that do not play a step
                        if (gate_cnt_q != 4'd0) begin
                            gate_cnt_d = gate_cnt_q - 4'd1;
                        end else begin
                            gate_cnt_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Playing reads the slot registers before any same-cycle write lands
        if (play_s) begin
            step_d = play_idx_s;
            if (slot_act_q[play_idx_s]) begin
                note_d     = slot_note_q[play_idx_s];
                trigger_d  = 1'b1;
                gate_cnt_d = gate_ticks;
            end else begin
                gate_cnt_d = 4'd0;
            end
        end else begin
            step_d = step_d;
        end

        gate_d    = (gate_cnt_d != 4'd0);
        running_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            note_q     <= '0;
            gate_q     <= 1'b0;
            trigger_q  <= 1'b0;
            step_q     <= '0;
            running_q  <= 1'b0;
            sub_cnt_q  <= 4'd0;
            gate_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            trigger_q  <= trigger_d;
            step_q     <= step_d;
            running_q  <= running_d;
            sub_cnt_q  <= sub_cnt_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    // Pattern slot storage; writes accepted in every state.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                slot_note_q[i] <= '0;
            end
            slot_act_q <= '0;
        end else if (wr_en) begin
            slot_note_q[wr_addr] <= wr_note;
            slot_act_q[wr_addr]  <= wr_active;
        end
    end

    assign note    = note_q;
    assign gate    = gate_q;
    assign trigger = trigger_q;
    assign step    = step_q;
    assign running = running_q;

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
// Self-checking bench for step_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

    localparam int STEPS = 16;
    localparam int NW    = 8;
    localparam int SW    = 4;

    logic          clock_in = 1'b0;
    logic          reset    = 1'b1;
    logic          tick     = 1'b0;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic [SW-1:0] last_step = '0;
    logic [3:0]    ticks_per_step = 4'd1;
    logic [3:0]    gate_ticks = 4'd1;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_addr = '0;
    logic [NW-1:0] wr_note = '0;
    logic          wr_active = 1'b0;
    logic [NW-1:0] note;
    logic          gate;
    logic          trigger;
    logic [SW-1:0] step;
    logic          running;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 waiting for first tick, 2 playing
    int m_mode, m_step, m_sub, m_gcnt, m_note, m_trig;
    int p_note [STEPS];
    bit p_act  [STEPS];

    step_sequencer #(.STEPS(STEPS), .NOTE_WIDTH(NW)) dut (
        .clock_in(clock_in), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .last_step(last_step), .ticks_per_step(ticks_per_step), .gate_ticks(gate_ticks),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_active(wr_active),
        .note(note), .gate(gate), .trigger(trigger), .step(step), .running(running)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_step = 0; m_sub = 0; m_gcnt = 0; m_note = 0; m_trig = 0;
        for (int i = 0; i < STEPS; i++) begin
            p_note[i] = 0;
            p_act[i]  = 1'b0;
        end
    endfunction

    // Applies the current inputs for one clock edge
    function automatic void model_clock();
        int tps;
        int play;
        play   = -1;
        m_trig = 0;
        if (stop) begin
            m_mode = 0; m_step = 0; m_sub = 0; m_gcnt = 0;
        end else if (start) begin
            m_mode = 1; m_step = 0; m_sub = 0; m_gcnt = 0;
        end else if (tick && m_mode == 1) begin
            play = 0; m_sub = 0; m_mode = 2;
        end else if (tick && m_mode == 2) begin
            tps = (ticks_per_step == 4'd0) ? 1 : int'(ticks_per_step);
            if (m_sub + 1 >= tps) begin
                play  = (m_step >= int'(last_step)) ? 0 : m_step + 1;
                m_sub = 0;
            end else begin
                m_sub++;
                if (m_gcnt > 0) m_gcnt--;
            end
        end
        if (play >= 0) begin
            m_step = play;
            if (p_act[play]) begin
                m_note = p_note[play];
                m_trig = 1;
                m_gcnt = int'(gate_ticks);
            end else begin
                m_gcnt = 0;
            end
        end
        if (wr_en) begin
            p_note[wr_addr] = int'(wr_note);
            p_act[wr_addr]  = wr_active;
        end
    endfunction

    task automatic cyc();
        model_clock();
        @(posedge clock_in);
        #1;
        chk("note",    int'(note),    m_note);
        chk("trigger", int'(trigger), m_trig);
        chk("gate",    int'(gate),    int'(m_gcnt != 0));
        chk("step",    int'(step),    m_step);
        chk("running", int'(running), int'(m_mode != 0));
        tick = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wr(input int a, input int n, input bit act);
        wr_en = 1'b1; wr_addr = SW'(a); wr_note = NW'(n); wr_active = act;
        cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
        end
    endtask

    initial begin
        int t2n [6];
        int t3g [8];
        t2n = '{10, 20, 30, 40, 10, 20};
        t3g = '{1, 1, 0, 0, 0, 0, 0, 0};
        model_reset();
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        chk("rst_note", int'(note), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_trig", int'(trigger), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_run",  int'(running), 0);

        // Basic four-step loop, one tick per step
        last_step = 4'd3; ticks_per_step = 4'd1; gate_ticks = 4'd1;
        for (int i = 0; i < 4; i++) wr(i, (i + 1) * 10, 1'b1);
        start = 1'b1; cyc();
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; cyc();
            chk("t2_note", int'(note), t2n[i]);
            chk("t2_trig", int'(trigger), 1);
            chk("t2_step", int'(step), i % 4);
        end
        cyc();
        chk("t2_trig_off", int'(trigger), 0);

        // Four ticks per step, short gate, rest on slot 1
        stop = 1'b1; cyc();
        ticks_per_step = 4'd4; gate_ticks = 4'd2; last_step = 4'd1;
        wr(0, 5, 1'b1);
        wr(1, 77, 1'b0);
        start = 1'b1; cyc();
        for (int k = 0; k < 8; k++) begin
            tick = 1'b1; cyc();
            chk("t3_gate", int'(gate), t3g[k]);
            chk("t3_step", int'(step), (k < 4) ? 0 : 1);
            chk("t3_trig", int'(trigger), int'(k == 0));
            chk("t3_note", int'(note), 5);
            cyc();
        end

        // Trigger-only, then legato
        stop = 1'b1; cyc();
        gate_ticks = 4'd0; ticks_per_step = 4'd1; last_step = 4'd3;
        for (int i = 0; i < 4; i++) wr(i, 100 + i, 1'b1);
        start = 1'b1; cyc();
        for (int k = 0; k < 4; k++) begin
            tick = 1'b1; cyc();
            chk("t4_trig", int'(trigger), 1);
            chk("t4_nogate", int'(gate), 0);
        end
        stop = 1'b1; cyc();
        gate_ticks = 4'd8; ticks_per_step = 4'd2;
        start = 1'b1; cyc();
        for (int k = 0; k < 12; k++) begin
            tick = 1'b1; cyc();
            chk("t4_legato", int'(gate), 1);
            chk("t4_trig2", int'(trigger), int'(k % 2 == 0));
            cyc();
            chk("t4_legato_gap", int'(gate), 1);
        end

        // Stop collisions
        tick = 1'b1; stop = 1'b1; cyc();
        chk("t5_trig", int'(trigger), 0);
        chk("t5_gate", int'(gate), 0);
        chk("t5_step", int'(step), 0);
        chk("t5_run",  int'(running), 0);
        start = 1'b1; stop = 1'b1; cyc();
        chk("t5_idle", int'(running), 0);
        tick = 1'b1; cyc();
        chk("t5_idle_tick", int'(trigger), 0);

        // Write/play collision and last_step changes
        ticks_per_step = 4'd1; last_step = 4'd15; gate_ticks = 4'd1;
        for (int i = 0; i < 16; i++) wr(i, 50 + i, 1'b1);
        start = 1'b1; cyc();
        ticks(6);
        chk("t6_at5", int'(step), 5);
        tick = 1'b1; wr_en = 1'b1; wr_addr = 4'd6; wr_note = 8'd99; wr_active = 1'b1;
        cyc();
        chk("t6_old_note", int'(note), 56);
        chk("t6_step6", int'(step), 6);
        last_step = 4'd6;
        ticks(7);
        chk("t6_new_note", int'(note), 99);
        chk("t6_step6b", int'(step), 6);
        ticks(6);
        chk("t6_at5b", int'(step), 5);
        last_step = 4'd2;
        ticks(1);
        chk("t6_wrap", int'(step), 0);
        chk("t6_wrap_note", int'(note), 50);

        // Asynchronous reset while the gate is high
        stop = 1'b1; cyc();
        gate_ticks = 4'd4; ticks_per_step = 4'd4; last_step = 4'd15;
        start = 1'b1; cyc();
        tick = 1'b1; cyc();
        chk("t1_gate_pre", int'(gate), 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t1_note", int'(note), 0);
        chk("t1_gate", int'(gate), 0);
        chk("t1_trig", int'(trigger), 0);
        chk("t1_step", int'(step), 0);
        chk("t1_run",  int'(running), 0);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        ticks_per_step = 4'd1; gate_ticks = 4'd3;
        start = 1'b1; cyc();
        for (int k = 0; k < 16; k++) begin
            tick = 1'b1; cyc();
            chk("t1_slot_inactive", int'(trigger), 0);
        end
        chk("t1_note_after", int'(note), 0);

        // Randomized traffic
        start = 1'b1; cyc();
        for (int c = 0; c < 2000; c++) begin
            tick  = ($urandom_range(1, 0) == 1);
            start = ($urandom_range(39, 0) == 0);
            stop  = ($urandom_range(59, 0) == 0);
            if ($urandom_range(7, 0) == 0) begin
                wr_en = 1'b1;
                wr_addr = SW'($urandom_range(15, 0));
                wr_note = NW'($urandom_range(255, 0));
                wr_active = ($urandom_range(3, 0) != 0);
            end
            if ($urandom_range(49, 0) == 0) last_step = SW'($urandom_range(15, 0));
            if ($urandom_range(49, 0) == 0) ticks_per_step = 4'($urandom_range(5, 0));
            if ($urandom_range(49, 0) == 0) gate_ticks = 4'($urandom_range(6, 0));
            if (!running && $urandom_range(9, 0) == 0) start = 1'b1;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Tick-driven pattern sequencer. It consumes the one-cycle subdivision pulse derived from the tempo divider and walks a programmable pattern of up to STEPS steps. For each active step it emits a note value, a one-cycle trigger and a gate of programmable length. It sits between the tempo generator and the oscillator/envelope voices and is the block that schedules note events against tempo.

Parameters:
STEPS, 16, number of pattern slots (power of two, 2..64)
NOTE_WIDTH, 8, width of stored note value
SW, $clog2(STEPS), step index width (derived, not overridable)

Ports:
clock_in  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle pulse per tempo subdivision, synchronous to clock_in
start  input  1  one-cycle pulse: arm and play from step 0
stop  input  1  one-cycle pulse: halt, gate off, step to 0
last_step  input  SW  index of final step before wrap
ticks_per_step  input  4  ticks per step; 0 treated as 1
gate_ticks  input  4  gate length in ticks; 0 = trigger only, no gate
wr_en  input  1  pattern write strobe
wr_addr  input  SW  pattern slot to write
wr_note  input  NOTE_WIDTH  note value for slot
wr_active  input  1  1 = slot plays, 0 = rest
note  output  NOTE_WIDTH  note of most recent active step
gate  output  1  held high for gate_ticks ticks after an active step
trigger  output  1  one-cycle pulse per active step
step  output  SW  index of step most recently played
running  output  1  high in ARMED or RUN

Behaviour:
- Reset (async): state IDLE; note=0, gate=0, trigger=0, step=0, running=0; sub_cnt=0, gate_cnt=0; all pattern slots inactive, note 0.
- FSM states:
  - IDLE: ignore tick. start -> ARMED.
  - ARMED: running=1, waiting for the first tick. That tick plays step 0, sets sub_cnt=0, and goes to RUN.
  - RUN: on tick, if sub_cnt >= ticks_per_step_eff-1, advance to the next step and set sub_cnt=0; otherwise sub_cnt+1.
- Next step: step+1; wraps to 0 when step >= last_step. Lowering last_step below the current step while running wraps at the next advance.
- Playing a step (registered; visible the cycle after the tick):
  - Active slot: note<=slot note; trigger=1 for exactly one cycle; gate_cnt<=gate_ticks; step<=index.
  - Inactive slot (rest): step<=index; note holds; no trigger; gate_cnt<=0.
- Gate countdown: on a RUN tick that does not play a step, gate_cnt decrements if nonzero. gate = (gate_cnt != 0), registered.
  - Example: gate_ticks=2, ticks_per_step=4. Gate rises one cycle after the step tick and falls one cycle after the 2nd following tick.
  - gate_ticks >= ticks_per_step gives legato: gate never drops between consecutive active steps, trigger still pulses.
- stop (any state): next cycle IDLE, gate=0, gate_cnt=0, trigger=0, step=0, sub_cnt=0, running=0; note holds.
- Simultaneous events:
  - stop and start in the same cycle: stop wins.
  - tick and stop in the same cycle: stop wins, no trigger.
  - start while RUN: return to ARMED with step=0, sub_cnt=0, gate forced low. The next tick plays step 0.
  - start and tick in the same cycle from IDLE: the tick is not consumed; the next tick plays step 0.
- Pattern writes are accepted in any state. When a write and a play of the same slot coincide, the play uses the old contents; the new data applies from the next visit.
- Pattern is register-based (no RAM inference required). Read is combinational from the slot array and registered into the outputs.
- Tick-to-output latency is exactly 1 clock_in cycle.

Test Plan:
1. Reset mid-RUN with gate=1: assert reset asynchronously -> all outputs 0 immediately, running=0, and all slots read inactive afterwards.
2. Write slots 0..3 notes 10,20,30,40, all active; last_step=3, ticks_per_step=1, gate_ticks=1; start then 6 ticks -> note sequence 10,20,30,40,10,20 with one trigger per tick, each one cycle after its tick; step 0,1,2,3,0,1.
3. ticks_per_step=4, gate_ticks=2, slot 0 active note 5, slot 1 inactive, last_step=1 -> step changes every 4th tick; gate high for 2 tick periods after step 0; slot 1 produces no trigger and gate stays 0; note stays 5.
4. gate_ticks=0 -> trigger pulses, gate never asserts. gate_ticks=8, ticks_per_step=2, all active -> gate stays 1 continuously while running, triggers every 2 ticks.
5. tick and stop in the same cycle -> no trigger, gate 0 next cycle, step=0, running=0. Start+stop together from IDLE -> remains IDLE.
6. While RUN at step 5: write slot 6 (note 99) on the same cycle as the tick that plays slot 6 -> old note output; the next visit to slot 6 outputs 99. Set last_step=2 while at step 5 -> next advance wraps to step 0.
